// File: rtl/kpn_pkg.sv
// Shared definitions for the KPN channel datapath: FIFO mode codes, default width, count sizing.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package kpn_pkg;

  localparam int KPN_FIFO_STANDARD = 0;
  localparam int KPN_FIFO_FWFT     = 1;
  localparam int KPN_BITS_NUMBER   = 16;

  // Width needed to hold an occupancy value in the range 0..depth inclusive.
  function automatic int kpn_count_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/kpn_fifo_storage.sv
// Simple dual-port register array backing the KPN channel.
// Latency: write lands at the clock edge; read data follows rd_addr combinationally.
// Backpressure: none; the caller only writes when a write has been accepted.
module kpn_fifo_storage #(
  parameter int BITS_NUMBER   = 16,
  parameter int FIFO_ELEMENTS = 5
) (
  input  logic                             clk,
  input  logic                             wr_en,
  input  logic [$clog2(FIFO_ELEMENTS)-1:0] wr_addr,
  input  logic [BITS_NUMBER-1:0]           wr_dat,
  input  logic [$clog2(FIFO_ELEMENTS)-1:0] rd_addr,
  output logic [BITS_NUMBER-1:0]           rd_dat
);

  logic [BITS_NUMBER-1:0] mem [FIFO_ELEMENTS];

  // Contents are never reset; occupancy bookkeeping in the channel decides what is live.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_dat;
    end
  end

  assign rd_dat = mem[rd_addr];

endmodule

// File: rtl/kpn_fifo_channel.sv
// Point-to-point KPN FIFO with flags, occupancy count, sticky error flags and optional FWFT output.
// Latency: standard mode 1 cycle rd->output_1/valid; FWFT mode head word visible the cycle after the write edge.
// Backpressure: writes refused when full unless a read is accepted together; reads refused when empty (no bypass).
module kpn_fifo_channel
  import kpn_pkg::*;
#(
  parameter int BITS_NUMBER        = KPN_BITS_NUMBER,
  parameter int FIFO_ELEMENTS      = 5,
  parameter int FWFT               = KPN_FIFO_STANDARD,
  parameter int ALMOST_FULL_LEVEL  = FIFO_ELEMENTS - 1,
  parameter int ALMOST_EMPTY_LEVEL = 1
) (
  input  logic                                        clk,
  input  logic                                        reset,
  input  logic                                        wr,
  input  logic [BITS_NUMBER-1:0]                      entry_1,
  input  logic                                        rd,
  output logic [BITS_NUMBER-1:0]                      output_1,
  output logic                                        valid,
  output logic                                        full,
  output logic                                        empty,
  output logic                                        almost_full,
  output logic                                        almost_empty,
  output logic [kpn_count_width(FIFO_ELEMENTS)-1:0]   count,
  input  logic                                        clear_errors,
  output logic                                        overflow,
  output logic                                        underflow
);

  localparam int AW = $clog2(FIFO_ELEMENTS);
  localparam int CW = kpn_count_width(FIFO_ELEMENTS);

  localparam logic [AW-1:0] LAST_PTR = AW'(FIFO_ELEMENTS - 1);
  localparam logic [CW-1:0] DEPTH    = CW'(FIFO_ELEMENTS);
  localparam logic [CW-1:0] AF_LEVEL = CW'(ALMOST_FULL_LEVEL);
  localparam logic [CW-1:0] AE_LEVEL = CW'(ALMOST_EMPTY_LEVEL);

  logic [AW-1:0]          wr_ptr;
  logic [AW-1:0]          rd_ptr;
  logic [CW-1:0]          count_q;
  logic [BITS_NUMBER-1:0] rd_dat;
  logic [BITS_NUMBER-1:0] dout_q;
  logic                   valid_q;
  logic                   rd_accept;
  logic                   wr_accept;

  // A full FIFO can still take a write when a read frees a slot in the same cycle;
  // an empty FIFO never forwards the incoming word to a same-cycle read.
  assign rd_accept = rd && !empty;
  assign wr_accept = wr && (!full || rd_accept);

  // Flags come straight from the registered count, so they describe the post-edge state.
  assign count        = count_q;
  assign full         = (count_q == DEPTH);
  assign empty        = (count_q == '0);
  assign almost_full  = (count_q >= AF_LEVEL);
  assign almost_empty = (count_q <= AE_LEVEL);

  kpn_fifo_storage #(
    .BITS_NUMBER   (BITS_NUMBER),
    .FIFO_ELEMENTS (FIFO_ELEMENTS)
  ) u_storage (
    .clk     (clk),
    .wr_en   (wr_accept && !reset),
    .wr_addr (wr_ptr),
    .wr_dat  (entry_1),
    .rd_addr (rd_ptr),
    .rd_dat  (rd_dat)
  );

  // Pointer and occupancy bookkeeping; pointers wrap by explicit compare so any depth works.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (wr_accept) begin
        wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
      end
      if (rd_accept) begin
        rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
      end
      case ({wr_accept, rd_accept})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Registered read path: output holds its last word, valid pulses for one cycle per accepted read.
  always_ff @(posedge clk) begin
    if (reset) begin
      dout_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= rd_accept;
      if (rd_accept) begin
        dout_q <= rd_dat;
      end
    end
  end

  // Sticky error flags; a fresh error in the same cycle as clear_errors keeps the flag set.
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr && !wr_accept) begin
        overflow <= 1'b1;
      end else if (clear_errors) begin
        overflow <= 1'b0;
      end
      if (rd && !rd_accept) begin
        underflow <= 1'b1;
      end else if (clear_errors) begin
        underflow <= 1'b0;
      end
    end
  end

  // FWFT shows the head word whenever something is stored; it reads as zero while empty
  // so stale storage never leaks out after reset.
  assign output_1 = (FWFT == KPN_FIFO_FWFT) ? (empty ? '0 : rd_dat) : dout_q;
  assign valid    = (FWFT == KPN_FIFO_FWFT) ? !empty : valid_q;

endmodule

// File: tb/tb_kpn_fifo_channel.sv
// Directed bench for kpn_fifo_channel: standard-mode instance checked by a read scoreboard,
// plus an FWFT instance checked directly.
// Inputs driven 1 time unit after the rising edge; outputs sampled on the falling edge or after that delay.
module tb_kpn_fifo_channel;
  import kpn_pkg::*;

  localparam int W = 16;
  localparam int D = 5;
  localparam int CW = kpn_count_width(D);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Standard-mode DUT signals
  logic          s_reset, s_wr, s_rd, s_clr;
  logic [W-1:0]  s_in, s_out;
  logic          s_valid, s_full, s_empty, s_af, s_ae, s_ovf, s_unf;
  logic [CW-1:0] s_count;

  // FWFT DUT signals
  logic          f_reset, f_wr, f_rd, f_clr;
  logic [W-1:0]  f_in, f_out;
  logic          f_valid, f_full, f_empty, f_af, f_ae, f_ovf, f_unf;
  logic [CW-1:0] f_count;

  kpn_fifo_channel #(
    .BITS_NUMBER(W), .FIFO_ELEMENTS(D), .FWFT(KPN_FIFO_STANDARD)
  ) dut_std (
    .clk(clk), .reset(s_reset), .wr(s_wr), .entry_1(s_in), .rd(s_rd),
    .output_1(s_out), .valid(s_valid), .full(s_full), .empty(s_empty),
    .almost_full(s_af), .almost_empty(s_ae), .count(s_count),
    .clear_errors(s_clr), .overflow(s_ovf), .underflow(s_unf)
  );

  kpn_fifo_channel #(
    .BITS_NUMBER(W), .FIFO_ELEMENTS(D), .FWFT(KPN_FIFO_FWFT)
  ) dut_fwft (
    .clk(clk), .reset(f_reset), .wr(f_wr), .entry_1(f_in), .rd(f_rd),
    .output_1(f_out), .valid(f_valid), .full(f_full), .empty(f_empty),
    .almost_full(f_af), .almost_empty(f_ae), .count(f_count),
    .clear_errors(f_clr), .overflow(f_ovf), .underflow(f_unf)
  );

  logic [W-1:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every valid word from the standard instance must match the next expected read.
  always @(negedge clk) begin
    if (s_valid === 1'b1) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL sb_unexpected: got valid word %0h expected no output", s_out);
      end else begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        if (s_out !== e) begin
          n_fail++;
          $display("FAIL sb_data: got %0h expected %0h", s_out, e);
        end
      end
    end
  end

  task automatic s_write(input logic [W-1:0] d);
    s_wr = 1'b1; s_in = d;
    step();
    s_wr = 1'b0;
  endtask

  task automatic s_read(input logic [W-1:0] e);
    s_rd = 1'b1;
    exp_q.push_back(e);
    step();
    s_rd = 1'b0;
  endtask

  logic [W-1:0] vals [5];

  initial begin
    vals[0] = 16'd10; vals[1] = 16'd20; vals[2] = 16'd30; vals[3] = 16'd40; vals[4] = 16'd50;
    s_reset = 1'b1; s_wr = 1'b0; s_rd = 1'b0; s_clr = 1'b0; s_in = '0;
    f_reset = 1'b1; f_wr = 1'b0; f_rd = 1'b0; f_clr = 1'b0; f_in = '0;
    step(); step();
    s_reset = 1'b0; f_reset = 1'b0;

    // Reset state
    chk("rst_count", 32'(s_count), 0);
    chk("rst_flags", {s_empty, s_full, s_ae, s_af}, 4'b1010);
    chk("rst_valid_out", {s_valid, s_out}, 0);
    chk("rst_errors", {s_ovf, s_unf}, 0);

    // Fill
    for (int i = 0; i < 5; i++) begin
      s_write(vals[i]);
      chk("fill_count", 32'(s_count), 32'(i + 1));
      chk("fill_almost_full", 32'(s_af), (i >= 3) ? 1 : 0);
      chk("fill_full", 32'(s_full), (i == 4) ? 1 : 0);
      if (i == 0) chk("fill_almost_empty_1", 32'(s_ae), 1);
      if (i == 1) chk("fill_almost_empty_2", 32'(s_ae), 0);
    end

    // Drain
    for (int i = 0; i < 5; i++) s_read(vals[i]);
    step();
    chk("drain_empty", {s_empty, 3'(s_count)}, {1'b1, 3'd0});
    chk("drain_valid_low", 32'(s_valid), 0);
    chk("drain_out_hold", 32'(s_out), 50);

    // Overflow
    for (int i = 0; i < 5; i++) s_write(vals[i]);
    s_write(16'd99);
    chk("ovf_count", 32'(s_count), 5);
    chk("ovf_flag", 32'(s_ovf), 1);
    s_clr = 1'b1; step(); s_clr = 1'b0;
    chk("ovf_cleared", 32'(s_ovf), 0);

    // Full with simultaneous read and write: 60 goes into the slot freed by 10 (wr pointer wraps)
    s_wr = 1'b1; s_rd = 1'b1; s_in = 16'd60;
    exp_q.push_back(16'd10);
    step();
    s_wr = 1'b0; s_rd = 1'b0;
    chk("full_rw_count", 32'(s_count), 5);
    chk("full_rw_no_ovf", 32'(s_ovf), 0);
    s_read(16'd20); s_read(16'd30); s_read(16'd40); s_read(16'd50); s_read(16'd60);
    step();
    chk("wrap_drain_empty", 32'(s_empty), 1);

    // Empty with simultaneous read and write: no bypass
    s_wr = 1'b1; s_rd = 1'b1; s_in = 16'd70;
    step();
    s_wr = 1'b0; s_rd = 1'b0;
    chk("empty_rw_count", 32'(s_count), 1);
    chk("empty_rw_underflow", 32'(s_unf), 1);
    chk("empty_rw_valid", 32'(s_valid), 0);
    s_read(16'd70);
    chk("empty_rw_after_count", 32'(s_count), 0);

    // Clear coinciding with a new error: set wins
    s_clr = 1'b1; s_rd = 1'b1; step(); s_clr = 1'b0; s_rd = 1'b0;
    chk("clr_vs_set", 32'(s_unf), 1);
    s_clr = 1'b1; step(); s_clr = 1'b0;
    chk("unf_cleared", 32'(s_unf), 0);

    // Reset mid-operation with a write in the reset cycle
    s_write(16'd1); s_write(16'd2); s_write(16'd3);
    s_rd = 1'b1; exp_q.push_back(16'd1); step(); s_rd = 1'b0;
    s_wr = 1'b1; s_write(16'd9); // leave a word pending; overflow not involved
    s_wr = 1'b1; s_in = 16'd77; s_reset = 1'b1;
    step();
    s_wr = 1'b0; s_reset = 1'b0;
    chk("midrst_count", 32'(s_count), 0);
    chk("midrst_empty", 32'(s_empty), 1);
    chk("midrst_out_valid", {s_valid, s_out}, 0);
    chk("midrst_errors", {s_ovf, s_unf}, 0);
    s_write(16'd88);
    chk("post_rst_count", 32'(s_count), 1);
    s_read(16'd88);

    // FWFT: head word visible the cycle after the write edge without any rd
    f_wr = 1'b1; f_in = 16'h00AA;
    step();
    f_wr = 1'b0;
    chk("fwft_out", 32'(f_out), 32'h00AA);
    chk("fwft_valid", 32'(f_valid), 1);
    step();
    chk("fwft_hold", {f_valid, f_out}, {1'b1, 16'h00AA});
    f_rd = 1'b1; step(); f_rd = 1'b0;
    chk("fwft_pop_empty", 32'(f_empty), 1);
    chk("fwft_pop_valid", 32'(f_valid), 0);

    step(); step();
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL sb_pending: got %0d unread expected words, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
